// File: rtl/core_out_streamer_if.sv
// Valid/ready beat stream from the output streamer to the host/DMA side.
interface core_out_streamer_if #(
    parameter int out_bw = 32
);
    logic              valid;
    logic              ready;
    logic              last;
    logic [out_bw-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/core_out_streamer.sv
// Captures core output words (optional per-lane ReLU) into a word FIFO and streams
// each word out as out_bw beats, lowest bits first. Overrun drops the word, sticky flag.
module core_out_streamer #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int out_bw  = 32,
    parameter int depth   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [psum_bw*col-1:0]   data_in,
    input  logic                     relu_en,
    core_out_streamer_if.master      m,
    output logic [$clog2(depth):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_overflow
);
    localparam int wordW = psum_bw * col;
    localparam int beats = wordW / out_bw;
    localparam int ptrW  = $clog2(depth);
    localparam int cntW  = ptrW + 1;
    localparam int beatW = (beats > 1) ? $clog2(beats) : 1;

    logic [wordW-1:0]             mem [depth];
    logic [ptrW-1:0]              wrPtr;
    logic [ptrW-1:0]              rdPtr;
    logic [beatW-1:0]             beatIdx;
    logic [wordW-1:0]             reluWord;
    logic [beats-1:0][out_bw-1:0] headBeats;
    logic                         handshake;
    logic                         lastBeat;
    logic                         pop;
    logic                         wrEn;
    logic                         drop;

    always_comb begin
        reluWord = data_in;
        for (int i = 0; i < col; i++) begin
            if (relu_en && data_in[psum_bw*(i+1)-1]) begin
                reluWord[psum_bw*i +: psum_bw] = '0;
            end
        end
    end

    assign full      = (count == cntW'(depth));
    assign empty     = (count == '0);
    assign lastBeat  = (beatIdx == beatW'(beats - 1));
    assign handshake = m.valid & m.ready;
    assign pop       = handshake & lastBeat;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign wrEn      = valid_in & ~reset & (~full | pop);
    assign drop      = valid_in & full & ~pop;

    assign headBeats = mem[rdPtr];
    assign m.valid   = ~empty;
    assign m.data    = headBeats[beatIdx];
    assign m.last    = m.valid & lastBeat;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= reluWord;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            beatIdx  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + ptrW'(1);
            end
            if (handshake) begin
                if (lastBeat) begin
                    beatIdx <= '0;
                    rdPtr   <= rdPtr + ptrW'(1);
                end else begin
                    beatIdx <= beatIdx + beatW'(1);
                end
            end
            if (wrEn && !pop) begin
                count <= count + cntW'(1);
            end else if (pop && !wrEn) begin
                count <= count - cntW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule
